// File: rtl/mem_stage_lsu_if.sv
// EX/MEM -> LSU -> RAM / MEM/WB signal bundle for mem_stage_lsu.
// master: the LSU (samples ex_*, ram_ack/ram_rdata; drives stall, ram_*, wb_*, misalign_err).
// slave : the surrounding pipeline and RAM (drives ex_*, ram_ack/ram_rdata; observes the rest).
interface mem_stage_lsu_if #(
  parameter int ADDR_W = 32,
  parameter int RD_W   = 5
);
  // EX/MEM bundle
  logic              ex_valid;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic [1:0]        ex_size;
  logic              ex_signed;
  logic [ADDR_W-1:0] ex_addr;
  logic [31:0]       ex_wdata;
  logic [RD_W-1:0]   ex_rd;
  logic              stall;
  // data RAM req/ack port
  logic              ram_req;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;
  logic              ram_ack;
  logic [31:0]       ram_rdata;
  // MEM/WB result
  logic              wb_valid;
  logic [RD_W-1:0]   wb_rd;
  logic [31:0]       wb_data;
  logic              misalign_err;

  modport master (
    input  ex_valid, ex_mem_read, ex_mem_write, ex_size, ex_signed, ex_addr, ex_wdata, ex_rd,
    input  ram_ack, ram_rdata,
    output stall, ram_req, ram_we, ram_addr, ram_be, ram_wdata,
    output wb_valid, wb_rd, wb_data, misalign_err
  );

  modport slave (
    output ex_valid, ex_mem_read, ex_mem_write, ex_size, ex_signed, ex_addr, ex_wdata, ex_rd,
    output ram_ack, ram_rdata,
    input  stall, ram_req, ram_we, ram_addr, ram_be, ram_wdata,
    input  wb_valid, wb_rd, wb_data, misalign_err
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: big-endian byte/half/word access to a req/ack data RAM.
// Latency: ALU pass-through 1 cycle; loads >= 2 cycles (ack in first BUSY cycle).
// Backpressure: stall is high from request issue until ram_ack; EX bundle is not sampled meanwhile.
// Ports: clk, reset (async, active-high), bus (mem_stage_lsu_if.master: ex_*, stall, ram_*, wb_*, misalign_err).
// Optional feature macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses trap instead of
// silently aligning down; when undefined misalign_err is tied low.
module mem_stage_lsu #(
  parameter int ADDR_W = 32,
  parameter int RD_W   = 5
) (
  input  logic            clk,
  input  logic            reset,
  mem_stage_lsu_if.master bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state;
  logic [1:0]      sz_q;     // normalised size of the outstanding access
  logic            sgn_q;
  logic [1:0]      off_q;    // byte offset within the word
  logic [RD_W-1:0] rd_q;

  logic [1:0]  sz_n;
  logic        is_mem;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [7:0]  byte_l;
  logic [15:0] half_l;
  logic [31:0] ld_c;

  // Reserved size 11 behaves as a word access.
  assign sz_n   = (bus.ex_size == 2'b11) ? 2'b10 : bus.ex_size;
  // read+write together is a load, so only the OR matters here.
  assign is_mem = bus.ex_mem_read | bus.ex_mem_write;

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign_c;
  assign misalign_c = ((sz_n == 2'b01) && bus.ex_addr[0]) ||
                      ((sz_n == 2'b10) && (bus.ex_addr[1:0] != 2'b00));
`else
  assign bus.misalign_err = 1'b0;
`endif

  // Byte enables and lane-replicated store data; bit3 is the most significant byte.
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = bus.ex_wdata;
    case (sz_n)
      2'b00: begin
        be_c    = 4'b1000 >> bus.ex_addr[1:0];
        wdata_c = {4{bus.ex_wdata[7:0]}};
      end
      2'b01: begin
        be_c    = bus.ex_addr[1] ? 4'b0011 : 4'b1100;
        wdata_c = {2{bus.ex_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Load extraction from the returned word using the latched access shape.
  always_comb begin
    byte_l = bus.ram_rdata[31:24];
    case (off_q)
      2'd1:    byte_l = bus.ram_rdata[23:16];
      2'd2:    byte_l = bus.ram_rdata[15:8];
      2'd3:    byte_l = bus.ram_rdata[7:0];
      default: ;
    endcase
    half_l = off_q[1] ? bus.ram_rdata[15:0] : bus.ram_rdata[31:16];
    case (sz_q)
      2'b00:   ld_c = {{24{sgn_q & byte_l[7]}}, byte_l};
      2'b01:   ld_c = {{16{sgn_q & half_l[15]}}, half_l};
      default: ld_c = bus.ram_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      sz_q          <= 2'b00;
      sgn_q         <= 1'b0;
      off_q         <= 2'b00;
      rd_q          <= '0;
      bus.stall     <= 1'b0;
      bus.ram_req   <= 1'b0;
      bus.ram_we    <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_be    <= 4'b0000;
      bus.ram_wdata <= 32'h0;
      bus.wb_valid  <= 1'b0;
      bus.wb_rd     <= '0;
      bus.wb_data   <= 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
      bus.misalign_err <= 1'b0;
`endif
    end else begin
      bus.wb_valid <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      bus.misalign_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          // ram_ack arriving here is stale (e.g. after a reset) and is ignored.
          if (bus.ex_valid && !bus.stall) begin
            if (!is_mem) begin
              bus.wb_valid <= 1'b1;
              bus.wb_rd    <= bus.ex_rd;
              bus.wb_data  <= 32'(bus.ex_addr);
            end
`ifdef LSU_MISALIGN_TRAP_EN
            else if (misalign_c) begin
              bus.misalign_err <= 1'b1;
            end
`endif
            else begin
              sz_q          <= sz_n;
              sgn_q         <= bus.ex_signed;
              off_q         <= bus.ex_addr[1:0];
              rd_q          <= bus.ex_rd;
              bus.ram_req   <= 1'b1;
              bus.ram_we    <= ~bus.ex_mem_read;
              bus.ram_addr  <= {bus.ex_addr[ADDR_W-1:2], 2'b00};
              bus.ram_be    <= be_c;
              bus.ram_wdata <= wdata_c;
              bus.stall     <= 1'b1;
              state         <= BUSY;
            end
          end
        end
        BUSY: begin
          // ram_* hold their values until the ack edge.
          if (bus.ram_ack) begin
            bus.ram_req <= 1'b0;
            bus.stall   <= 1'b0;
            state       <= IDLE;
            if (!bus.ram_we) begin
              bus.wb_valid <= 1'b1;
              bus.wb_rd    <= rd_q;
              bus.wb_data  <= ld_c;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  mem_stage_lsu_if #(.ADDR_W(32), .RD_W(5)) bus ();

  mem_stage_lsu #(.ADDR_W(32), .RD_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mr;
    logic        mw;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] a;
    logic [31:0] wd;
    logic [4:0]  rd;
    int          dly;
    logic [31:0] rdat;
    logic [3:0]  be;
    logic [31:0] dat;   // wb_data for loads, ram_wdata for stores
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic mr, input logic mw, input logic [1:0] sz, input logic sg,
                              input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                              input int dly, input logic [31:0] rdat, input logic [3:0] be,
                              input logic [31:0] dat);
    vec_t v;
    v.mr = mr; v.mw = mw; v.sz = sz; v.sg = sg; v.a = a; v.wd = wd; v.rd = rd;
    v.dly = dly; v.rdat = rdat; v.be = be; v.dat = dat;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one EX bundle, service the RAM with an ack in BUSY cycle 'dly', and check every
  // cycle against expectations derived from the access rules (lane position, mask, replication).
  task automatic do_op(input logic mr, input logic mw, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rdi,
                       input int dly, input logic [31:0] rdat,
                       output logic [3:0] obe, output logic [31:0] odat);
    logic        is_mem, mis;
    int          sizeb, off, sh;
    logic [31:0] mask, ewd, ewb, mult;
    logic [3:0]  ebe;
    is_mem = mr | mw;
    sizeb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    mis    = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    mis = is_mem && ((int'(a[1:0]) % sizeb) != 0);
`endif
    off  = (int'(a[1:0]) / sizeb) * sizeb;       // low address bits beyond the size are ignored
    sh   = 8 * (4 - off - sizeb);                 // big-endian: lane offset 0 is the top byte
    mask = 32'((64'd1 << (8 * sizeb)) - 64'd1);
    ebe  = 4'(((1 << sizeb) - 1) << (4 - off - sizeb));
    mult = (sizeb == 1) ? 32'h01010101 : (sizeb == 2) ? 32'h00010001 : 32'h1;
    ewd  = (wd & mask) * mult;
    ewb  = (rdat >> sh) & mask;
    if (sg && sizeb < 4 && ewb[8*sizeb-1]) ewb = ewb | ~mask;
    obe  = 4'b0;
    odat = 32'h0;

    bus.ex_valid = 1'b1; bus.ex_mem_read = mr; bus.ex_mem_write = mw; bus.ex_size = sz;
    bus.ex_signed = sg; bus.ex_addr = a; bus.ex_wdata = wd; bus.ex_rd = rdi;
    step();
    bus.ex_valid = 1'b0;
    if (!is_mem) begin
      chk("alu_wb_valid", 32'(bus.wb_valid), 32'd1);
      chk("alu_wb_rd", 32'(bus.wb_rd), 32'(rdi));
      chk("alu_wb_data", bus.wb_data, a);
      chk("alu_stall", 32'(bus.stall), 32'd0);
      chk("alu_ram_req", 32'(bus.ram_req), 32'd0);
      odat = bus.wb_data;
    end else if (mis) begin
      chk("mis_err", 32'(bus.misalign_err), 32'd1);
      chk("mis_req", 32'(bus.ram_req), 32'd0);
      chk("mis_stall", 32'(bus.stall), 32'd0);
      chk("mis_wb_valid", 32'(bus.wb_valid), 32'd0);
      step();
      chk("mis_err_pulse", 32'(bus.misalign_err), 32'd0);
      chk("mis_req_after", 32'(bus.ram_req), 32'd0);
    end else begin
      chk("req", 32'(bus.ram_req), 32'd1);
      chk("we", 32'(bus.ram_we), 32'(!mr));
      chk("addr", bus.ram_addr, {a[31:2], 2'b00});
      chk("be", 32'(bus.ram_be), 32'(ebe));
      if (!mr) chk("wdata", bus.ram_wdata, ewd);
      chk("stall", 32'(bus.stall), 32'd1);
      chk("wb_idle", 32'(bus.wb_valid), 32'd0);
      obe = bus.ram_be;
      if (!mr) odat = bus.ram_wdata;
      // An ALU bundle offered while stalled must be ignored.
      bus.ex_valid = 1'b1; bus.ex_mem_read = 1'b0; bus.ex_mem_write = 1'b0;
      bus.ex_addr = $urandom; bus.ex_rd = 5'($urandom);
      for (int c = 1; c < dly; c++) begin
        bus.ram_rdata = $urandom;
        step();
        chk("busy_stall", 32'(bus.stall), 32'd1);
        chk("busy_req", 32'(bus.ram_req), 32'd1);
        chk("busy_addr", bus.ram_addr, {a[31:2], 2'b00});
        chk("busy_wb", 32'(bus.wb_valid), 32'd0);
      end
      bus.ram_ack = 1'b1;
      bus.ram_rdata = rdat;
      step();
      bus.ram_ack = 1'b0;
      bus.ex_valid = 1'b0;
      chk("ack_req", 32'(bus.ram_req), 32'd0);
      chk("ack_stall", 32'(bus.stall), 32'd0);
      chk("ack_wb_valid", 32'(bus.wb_valid), 32'(mr));
      if (mr) begin
        chk("ld_data", bus.wb_data, ewb);
        chk("ld_rd", 32'(bus.wb_rd), 32'(rdi));
        odat = bus.wb_data;
      end
    end
    step();
    chk("wb_pulse_end", 32'(bus.wb_valid), 32'd0);
  endtask

  initial begin
    logic [3:0]  obe;
    logic [31:0] odat;

    reset = 1'b1;
    bus.ex_valid = 1'b0; bus.ex_mem_read = 1'b0; bus.ex_mem_write = 1'b0; bus.ex_size = 2'b00;
    bus.ex_signed = 1'b0; bus.ex_addr = 32'h0; bus.ex_wdata = 32'h0; bus.ex_rd = 5'd0;
    bus.ram_ack = 1'b0; bus.ram_rdata = 32'h0;
    step();
    step();
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_req", 32'(bus.ram_req), 32'd0);
    chk("rst_we", 32'(bus.ram_we), 32'd0);
    chk("rst_addr", bus.ram_addr, 32'd0);
    chk("rst_be", 32'(bus.ram_be), 32'd0);
    chk("rst_wdata", bus.ram_wdata, 32'd0);
    chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("rst_wb_rd", 32'(bus.wb_rd), 32'd0);
    chk("rst_wb_data", bus.wb_data, 32'd0);
    chk("rst_mis", 32'(bus.misalign_err), 32'd0);
    reset = 1'b0;
    step();

    //                mr    mw    sz     sg    addr          wdata         rd  dly rdata         be       data
    tbl.push_back(mk(1'b1, 1'b0, 2'd1, 1'b1, 32'h0000_0102, 32'h0,        5'd3, 3, 32'h1234_8001, 4'b0011, 32'hFFFF_8001));
    tbl.push_back(mk(1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0203, 32'h0,        5'd4, 1, 32'hAABB_CCDD, 4'b0001, 32'h0000_00DD));
    tbl.push_back(mk(1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_0011, 32'h0000_005A, 5'd0, 2, 32'h0,        4'b0100, 32'h5A5A_5A5A));
    tbl.push_back(mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0040, 32'h0,        5'd7, 2, 32'hCAFE_BABE, 4'b1111, 32'hCAFE_BABE));
    tbl.push_back(mk(1'b1, 1'b0, 2'd0, 1'b1, 32'h0000_0040, 32'h0,        5'd8, 1, 32'h8012_3456, 4'b1000, 32'hFFFF_FF80));
    tbl.push_back(mk(1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_0100, 32'h0,        5'd9, 4, 32'h89AB_0000, 4'b1100, 32'h0000_89AB));
    tbl.push_back(mk(1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_0022, 32'hDEAD_1234, 5'd0, 1, 32'h0,        4'b0011, 32'h1234_1234));
    tbl.push_back(mk(1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_0030, 32'h0102_0304, 5'd0, 3, 32'h0,        4'b1111, 32'h0102_0304));
    tbl.push_back(mk(1'b1, 1'b0, 2'd3, 1'b1, 32'h0000_0050, 32'h0,        5'd10, 1, 32'h1122_3344, 4'b1111, 32'h1122_3344));
    tbl.push_back(mk(1'b1, 1'b1, 2'd0, 1'b0, 32'h0000_0061, 32'h0,        5'd11, 2, 32'h00F0_0000, 4'b0100, 32'h0000_00F0));
`ifndef LSU_MISALIGN_TRAP_EN
    tbl.push_back(mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0002, 32'h0,        5'd12, 1, 32'h5566_7788, 4'b1111, 32'h5566_7788));
    tbl.push_back(mk(1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_0103, 32'h0,        5'd13, 2, 32'h1111_ABCD, 4'b0011, 32'h0000_ABCD));
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      do_op(tbl[i].mr, tbl[i].mw, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].wd, tbl[i].rd,
            tbl[i].dly, tbl[i].rdat, obe, odat);
      chk($sformatf("tbl%0d_be", i), 32'(obe), 32'(tbl[i].be));
      chk($sformatf("tbl%0d_data", i), odat, tbl[i].dat);
    end

    // ALU pass-through
    do_op(1'b0, 1'b0, 2'd2, 1'b0, 32'h77, 32'h0, 5'd5, 1, 32'h0, obe, odat);
    chk("alu_77", odat, 32'h77);

`ifdef LSU_MISALIGN_TRAP_EN
    do_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h2, 32'h0, 5'd6, 1, 32'h0, obe, odat);
    do_op(1'b0, 1'b1, 2'd1, 1'b0, 32'h5, 32'h0, 5'd0, 1, 32'h0, obe, odat);
`endif

    // Reset while BUSY: request drops at once, late ack is ignored.
    bus.ex_valid = 1'b1; bus.ex_mem_read = 1'b1; bus.ex_mem_write = 1'b0; bus.ex_size = 2'd2;
    bus.ex_addr = 32'h80; bus.ex_rd = 5'd9;
    step();
    bus.ex_valid = 1'b0;
    chk("rb_req", 32'(bus.ram_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rb_req_drop", 32'(bus.ram_req), 32'd0);
    chk("rb_stall_drop", 32'(bus.stall), 32'd0);
    #2 reset = 1'b0;
    bus.ram_ack = 1'b1;
    bus.ram_rdata = 32'h1234_5678;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rb_late_ack_wb", 32'(bus.wb_valid), 32'd0);
      chk("rb_late_ack_req", 32'(bus.ram_req), 32'd0);
    end
    bus.ram_ack = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        bus.ex_valid = 1'b0;
        bus.ram_ack = 1'($urandom);
        bus.ex_addr = $urandom;
        step();
        bus.ram_ack = 1'b0;
        chk("rnd_idle_wb", 32'(bus.wb_valid), 32'd0);
        chk("rnd_idle_req", 32'(bus.ram_req), 32'd0);
      end else if (kind <= 2) begin
        do_op(1'b0, 1'b0, 2'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom),
              1, 32'h0, obe, odat);
      end else begin
        logic mr, mw;
        mr = 1'($urandom);
        mw = mr ? 1'($urandom) : 1'b1;
        do_op(mr, mw, 2'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom),
              $urandom_range(1, 4), $urandom, obe, odat);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
